aes_spi_slave: RTL and testbench

SPI slave front end that sits directly upstream of the AES encryption core. It deserialises a 256-bit command frame (plaintext then key) from an external SPI master, presents plaintext and key to the core over a valid/ready handshake, and captures the 128-bit ciphertext. It shifts that ciphertext back out on MISO during the next frame. All SPI pins are oversampled in the single system clock domain.

---
 rtl/aes_spi_pkg.sv | 21 ++
 rtl/spi_edge_sync.sv | 38 +++
 rtl/aes_spi_slave.sv | 161 ++++++++++++++++
 tb/tb_aes_spi_slave.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_spi_pkg.sv
// Shared types and constants for the AES SPI slave front end.
package aes_spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

  localparam int FRAME_BITS = 256;
  localparam int BLK_BITS   = 128;
  // One extra count above a full frame marks "too long" and saturates there
  localparam int CNT_W      = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME_BITS + 1);

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] cnt);
    return (cnt == CNT_MAX) ? cnt : cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Synchroniser for one SPI pin: delayed level plus registered rise/fall pulses.
module spi_edge_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   level_r;
  logic                   rise_r;
  logic                   fall_r;

  // Sync chain; level and edge pulses come out together, SYNC_STAGES+1 cycles after the pin
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r  <= {SYNC_STAGES{RESET_VAL}};
      level_r <= RESET_VAL;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
    end else begin
      sync_r  <= {sync_r[SYNC_STAGES-2:0], pin};
      level_r <= sync_r[SYNC_STAGES-1];
      rise_r  <= sync_r[SYNC_STAGES-1] & ~level_r;
      fall_r  <= ~sync_r[SYNC_STAGES-1] & level_r;
    end
  end

  assign level = level_r;
  assign rise  = rise_r;
  assign fall  = fall_r;

endmodule

// File: rtl/aes_spi_slave.sv
// SPI slave front end for the AES core: 256-bit command frame in, ciphertext out on MISO.
// Optional AES_SPI_KEY_CACHE_EN: accept 128-bit plaintext-only frames reusing the last key.
module aes_spi_slave
  import aes_spi_pkg::*;
#(
  parameter int DATA_W      = BLK_BITS,
  parameter int KEY_W       = BLK_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_n,
  input  logic              sclk,
  input  logic              mosi,
  output logic              miso,
  output logic              blk_valid,
  input  logic              blk_ready,
  output logic [DATA_W-1:0] blk_data,
  output logic [KEY_W-1:0]  blk_key,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data,
  output logic              busy,
  output logic              frame_err
);

  localparam int FRAME_W = DATA_W + KEY_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_W);
`ifdef AES_SPI_KEY_CACHE_EN
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(DATA_W);
`endif

  logic sclk_rise_s, sclk_fall_s, sclk_level_unused_s;
  logic cs_rise_s, cs_fall_s, cs_level_unused_s;
  logic mosi_level_s, mosi_rise_unused_s, mosi_fall_unused_s;

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .pin(sclk),
    .level(sclk_level_unused_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
  );

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .pin(cs_n),
    .level(cs_level_unused_s), .rise(cs_rise_s), .fall(cs_fall_s)
  );

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .pin(mosi),
    .level(mosi_level_s), .rise(mosi_rise_unused_s), .fall(mosi_fall_unused_s)
  );

  state_t              state_r;
  logic [FRAME_W-1:0]  rx_r;
  logic [DATA_W-1:0]   tx_r;
  logic [DATA_W-1:0]   res_r;
  logic [CNT_W-1:0]    cnt_r;
  logic                frame_act_r;
  logic                ovr_r;
  logic                miso_r;
  logic                blk_valid_r;
  logic [DATA_W-1:0]   blk_data_r;
  logic [KEY_W-1:0]    blk_key_r;
  logic                busy_r;
  logic                frame_err_r;

  // Frame shifting and the IDLE/RECV/ISSUE/WAIT control, all outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      rx_r        <= {FRAME_W{1'b0}};
      tx_r        <= {DATA_W{1'b0}};
      res_r       <= {DATA_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      frame_act_r <= 1'b0;
      ovr_r       <= 1'b0;
      miso_r      <= 1'b0;
      blk_valid_r <= 1'b0;
      blk_data_r  <= {DATA_W{1'b0}};
      blk_key_r   <= {KEY_W{1'b0}};
      busy_r      <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      frame_err_r <= 1'b0;
      if (cs_fall_s) begin
        frame_act_r <= 1'b1;
        cnt_r       <= {CNT_W{1'b0}};
        if (state_r == ST_IDLE) begin
          state_r <= ST_RECV;
          busy_r  <= 1'b1;
          ovr_r   <= 1'b0;
          tx_r    <= res_r;
          miso_r  <= res_r[DATA_W-1];
        end else begin
          // Overrun: the frame is clocked through but never issued, and MISO stays quiet
          ovr_r  <= 1'b1;
          tx_r   <= {DATA_W{1'b0}};
          miso_r <= 1'b0;
        end
      end else if (frame_act_r && sclk_rise_s) begin
        rx_r  <= {rx_r[FRAME_W-2:0], mosi_level_s};
        cnt_r <= cnt_inc(cnt_r);
      end else if (frame_act_r && sclk_fall_s) begin
        tx_r   <= {tx_r[DATA_W-2:0], 1'b0};
        miso_r <= tx_r[DATA_W-2];
      end else if (frame_act_r && cs_rise_s) begin
        frame_act_r <= 1'b0;
        tx_r        <= {DATA_W{1'b0}};
        miso_r      <= 1'b0;
        if (ovr_r) begin
          frame_err_r <= 1'b1;
        end else if (cnt_r == FULL_CNT) begin
          blk_data_r  <= rx_r[FRAME_W-1:KEY_W];
          blk_key_r   <= rx_r[KEY_W-1:0];
          blk_valid_r <= 1'b1;
          state_r     <= ST_ISSUE;
`ifdef AES_SPI_KEY_CACHE_EN
        end else if (cnt_r == HALF_CNT) begin
          blk_data_r  <= rx_r[DATA_W-1:0];
          blk_valid_r <= 1'b1;
          state_r     <= ST_ISSUE;
`endif
        end else begin
          frame_err_r <= 1'b1;
          busy_r      <= 1'b0;
          state_r     <= ST_IDLE;
        end
      end else begin
        frame_act_r <= frame_act_r;
      end

      case (state_r)
        ST_ISSUE: begin
          if (blk_ready) begin
            blk_valid_r <= 1'b0;
            state_r     <= ST_WAIT;
          end else begin
            blk_valid_r <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (res_valid) begin
            res_r   <= res_data;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            res_r <= res_r;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign miso      = miso_r;
  assign blk_valid = blk_valid_r;
  assign blk_data  = blk_data_r;
  assign blk_key   = blk_key_r;
  assign busy      = busy_r;
  assign frame_err = frame_err_r;

endmodule

// File: tb/tb_aes_spi_slave.sv
// Scoreboard bench for aes_spi_slave; follows AES_SPI_KEY_CACHE_EN like the design.
module tb_aes_spi_slave;

  localparam int HALF = 8;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT2 = 128'hdeadbeef0badf00dcafebabe12345678;
  localparam logic [127:0] PT3 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] PT4 = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] R2  = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] R3  = 128'h55aa33cc0ff0a5a5123456789abcdef0;

  logic         clk = 1'b0;
  logic         rst;
  logic         cs_n, sclk, mosi, miso;
  logic         blk_valid, blk_ready;
  logic [127:0] blk_data, blk_key;
  logic         res_valid;
  logic [127:0] res_data;
  logic         busy, frame_err;

  int vectors = 0;
  int miscompares = 0;
  int err_cnt = 0;
  int valid_cnt = 0;
  logic [255:0] exp_q[$];
  logic [255:0] obs_q[$];

  always #5 clk = ~clk;

  aes_spi_slave #(.DATA_W(128), .KEY_W(128), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .cs_n(cs_n), .sclk(sclk), .mosi(mosi), .miso(miso),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data), .blk_key(blk_key),
    .res_valid(res_valid), .res_data(res_data), .busy(busy), .frame_err(frame_err)
  );

  // Monitor: record each accepted block, frame_err pulses and cycles with blk_valid high
  always @(negedge clk) begin
    if (!rst) begin
      if (blk_valid && blk_ready) obs_q.push_back({blk_data, blk_key});
      if (frame_err) err_cnt <= err_cnt + 1;
      if (blk_valid) valid_cnt <= valid_cnt + 1;
    end
  end

  task automatic spi_frame(input logic [255:0] bits, input int nbits, output logic [255:0] rd);
    rd = '0;
    cs_n = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    for (int i = 0; i < nbits; i++) begin
      mosi = bits[255-i];
      repeat (HALF) @(posedge clk);
      #1;
      rd[255-i] = miso;
      sclk = 1'b1;
      repeat (HALF) @(posedge clk);
      #1;
      sclk = 1'b0;
    end
    repeat (12) @(posedge clk);
    #1;
    cs_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic await_obs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      if (obs_q.size() != 0) ok = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic core_result(input logic [127:0] val);
    res_valid = 1'b1;
    res_data  = val;
    @(posedge clk);
    #1;
    res_valid = 1'b0;
    res_data  = 128'h0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({miso, blk_valid, busy, frame_err} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_ctrl got=%b want=0000", {miso, blk_valid, busy, frame_err});
    end
    vectors++;
    if ({blk_data, blk_key} !== 256'h0) begin
      miscompares++;
      $display("FAIL reset_data got=%h want=0", {blk_data, blk_key});
    end
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    vectors++;
    if ({miso, blk_valid, busy, frame_err} !== 4'b0000) begin
      miscompares++;
      $display("FAIL post_reset_ctrl got=%b want=0000", {miso, blk_valid, busy, frame_err});
    end
  endtask

  task automatic test_basic;
    logic [255:0] rd, obs, exp;
    bit ok;
    blk_ready = 1'b1;
    exp_q.push_back({PT, KEY});
    spi_frame({PT, KEY}, 256, rd);
    await_obs(ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL basic_accept got=none want=handshake");
    end else begin
      obs = obs_q.pop_front();
      exp = exp_q.pop_front();
      vectors++;
      if (obs[255:128] !== exp[255:128]) begin
        miscompares++;
        $display("FAIL basic_data got=%h want=%h", obs[255:128], exp[255:128]);
      end
      vectors++;
      if (obs[127:0] !== exp[127:0]) begin
        miscompares++;
        $display("FAIL basic_key got=%h want=%h", obs[127:0], exp[127:0]);
      end
    end
    vectors++;
    if (obs_q.size() != 0 || blk_valid !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_single got=extra%0d/valid%b/busy%b want=0/0/1", obs_q.size(), blk_valid, busy);
    end
    core_result(CT);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_busy_drop got=%b want=0", busy);
    end
  endtask

  task automatic test_readback;
    logic [255:0] rd, obs;
    bit ok;
    core_result(128'hbad0bad0bad0bad0bad0bad0bad0bad0);
    exp_q.push_back({PT2, KEY});
    spi_frame({PT2, KEY}, 256, rd);
    vectors++;
    if (rd[255:128] !== CT) begin
      miscompares++;
      $display("FAIL readback_ct got=%h want=%h", rd[255:128], CT);
    end
    vectors++;
    if (rd[127:0] !== 128'h0) begin
      miscompares++;
      $display("FAIL readback_tail got=%h want=0", rd[127:0]);
    end
    await_obs(ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL readback_accept got=none want=handshake");
    end else begin
      obs = obs_q.pop_front();
      vectors++;
      if (obs !== exp_q.pop_front()) begin
        miscompares++;
        $display("FAIL readback_block got=%h want=%h", obs, {PT2, KEY});
      end
    end
    core_result(R2);
  endtask

  task automatic test_short;
    logic [255:0] rd;
    int e0, v0;
    e0 = err_cnt;
    v0 = valid_cnt;
    spi_frame({PT3, KEY}, 200, rd);
    vectors++;
    if (err_cnt !== e0 + 1) begin
      miscompares++;
      $display("FAIL short_err got=%0d want=%0d", err_cnt - e0, 1);
    end
    vectors++;
    if (valid_cnt !== v0 || obs_q.size() != 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL short_quiet got=valid%0d/busy%b want=0/0", valid_cnt - v0, busy);
    end
    vectors++;
    if (rd[255:128] !== R2) begin
      miscompares++;
      $display("FAIL short_miso got=%h want=%h", rd[255:128], R2);
    end
  endtask

  task automatic test_backpressure;
    logic [255:0] rd, obs;
    bit ok;
    blk_ready = 1'b0;
    exp_q.push_back({PT3, KEY});
    spi_frame({PT3, KEY}, 256, rd);
    vectors++;
    if (rd[255:128] !== R2) begin
      miscompares++;
      $display("FAIL bp_miso got=%h want=%h", rd[255:128], R2);
    end
    for (int c = 0; c < 10; c++) begin
      vectors++;
      if (blk_valid !== 1'b1 || blk_data !== PT3 || blk_key !== KEY) begin
        miscompares++;
        $display("FAIL bp_hold cyc=%0d got=%b/%h want=1/%h", c, blk_valid, blk_data, PT3);
      end
      @(posedge clk);
      #1;
    end
    blk_ready = 1'b1;
    @(posedge clk);
    #1;
    blk_ready = 1'b0;
    await_obs(ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL bp_accept got=none want=handshake");
    end else begin
      obs = obs_q.pop_front();
      vectors++;
      if (obs !== exp_q.pop_front()) begin
        miscompares++;
        $display("FAIL bp_block got=%h want=%h", obs, {PT3, KEY});
      end
    end
    vectors++;
    if (blk_valid !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_wait got=valid%b/busy%b want=0/1", blk_valid, busy);
    end
  endtask

  task automatic test_back_to_back;
    logic [255:0] rd;
    int e0;
    e0 = err_cnt;
    fork
      spi_frame({PT, KEY}, 256, rd);
      begin
        repeat (400) @(posedge clk);
        #1;
        core_result(R3);
      end
    join
    vectors++;
    if (err_cnt !== e0 + 1) begin
      miscompares++;
      $display("FAIL overrun_err got=%0d want=%0d", err_cnt - e0, 1);
    end
    vectors++;
    if (rd !== 256'h0) begin
      miscompares++;
      $display("FAIL overrun_miso got=%h want=0", rd);
    end
    vectors++;
    if (obs_q.size() != 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL overrun_quiet got=accepts%0d/busy%b want=0/0", obs_q.size(), busy);
    end
  endtask

  task automatic test_key_cache;
    logic [255:0] rd;
    int e0;
`ifdef AES_SPI_KEY_CACHE_EN
    logic [255:0] obs;
    bit ok;
    blk_ready = 1'b1;
    exp_q.push_back({PT4, KEY});
`endif
    e0 = err_cnt;
    spi_frame({PT4, 128'h0}, 128, rd);
    vectors++;
    if (rd[255:128] !== R3) begin
      miscompares++;
      $display("FAIL cache_miso got=%h want=%h", rd[255:128], R3);
    end
`ifdef AES_SPI_KEY_CACHE_EN
    await_obs(ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL cache_accept got=none want=handshake");
    end else begin
      obs = obs_q.pop_front();
      vectors++;
      if (obs !== exp_q.pop_front()) begin
        miscompares++;
        $display("FAIL cache_block got=%h want=%h", obs, {PT4, KEY});
      end
    end
    core_result(R2);
    vectors++;
    if (err_cnt !== e0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL cache_clean got=err%0d/busy%b want=0/0", err_cnt - e0, busy);
    end
`else
    vectors++;
    if (err_cnt !== e0 + 1 || obs_q.size() != 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL short128_err got=err%0d/accepts%0d/busy%b want=1/0/0", err_cnt - e0, obs_q.size(), busy);
    end
`endif
  endtask

  initial begin
    rst       = 1'b1;
    cs_n      = 1'b1;
    sclk      = 1'b0;
    mosi      = 1'b0;
    blk_ready = 1'b0;
    res_valid = 1'b0;
    res_data  = 128'h0;
    test_reset();
    test_basic();
    test_readback();
    test_short();
    test_backpressure();
    test_back_to_back();
    test_key_cache();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
